// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the byte producers, the round-robin arbiter and the UART transmitter.
// The master modport is the arbiter's view; slave is the surrounding environment.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] data_in;
  logic [NUM_REQ-1:0]        ack;
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_start;
  logic                      tx_busy;
  logic [ID_W-1:0]           grant_id;
  logic                      active;
  logic                      timeout_err;

  modport master (
    input  req, data_in, tx_busy,
    output ack, tx_data, tx_start, grant_id, active, timeout_err
  );

  modport slave (
    output req, data_in, tx_busy,
    input  ack, tx_data, tx_start, grant_id, active, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers,
// with a watchdog that abandons a grant if the transmitter never raises busy.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  uart_tx_arbiter_if.master bus
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t              state, state_d;
  logic [ID_W-1:0]     ptr, ptr_d;
  logic [CNT_W-1:0]    cnt, cnt_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic [ID_W-1:0]     gid_q, gid_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic                start_q, start_d;
  logic                active_q, active_d;
  logic                err_q, err_d;

  logic                sel_found;
  logic [ID_W-1:0]     sel_idx;
  logic [DATA_W-1:0]   sel_data;

  // Scan from the pointer to the top first, then wrap to the bottom.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!sel_found && bus.req[i] && (ID_W'(i) >= ptr)) begin
        sel_found = 1'b1;
        sel_idx   = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!sel_found && bus.req[i]) begin
        sel_found = 1'b1;
        sel_idx   = ID_W'(i);
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel_idx == ID_W'(i)) sel_data = bus.data_in[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    state_d   = state;
    ptr_d     = ptr;
    cnt_d     = cnt;
    tx_data_d = tx_data_q;
    gid_d     = gid_q;
    ack_d     = '0;
    start_d   = 1'b0;
    err_d     = 1'b0;

    case (state)
      IDLE: begin
        if (sel_found && !bus.tx_busy) begin
          gid_d          = sel_idx;
          tx_data_d      = sel_data;
          ack_d[sel_idx] = 1'b1;
          start_d        = 1'b1;
          state_d        = ISSUE;
        end
      end
      ISSUE: begin
        ptr_d   = (gid_q == ID_W'(NUM_REQ-1)) ? '0 : gid_q + 1'b1;
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        // Busy arriving on the same edge the counter would reach TIMEOUT-1 wins over the abort.
        if (bus.tx_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt == CNT_W'(TIMEOUT-2)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    active_d = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= '0;
      tx_data_q <= '0;
      gid_q     <= '0;
      ack_q     <= '0;
      start_q   <= 1'b0;
      active_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_d;
      ptr       <= ptr_d;
      cnt       <= cnt_d;
      tx_data_q <= tx_data_d;
      gid_q     <= gid_d;
      ack_q     <= ack_d;
      start_q   <= start_d;
      active_q  <= active_d;
      err_q     <= err_d;
    end
  end

  assign bus.ack         = ack_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.tx_start    = start_q;
  assign bus.grant_id    = gid_q;
  assign bus.active      = active_q;
  assign bus.timeout_err = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench: expected grants are queued as stimulus is driven and
// compared against every tx_start pulse the arbiter produces.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .DATA_W(DATA_W)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ), .ID_W(ID_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic expect_grant(input int id, input logic [DATA_W-1:0] data);
    exp_t e;
    e.id   = ID_W'(id);
    e.data = data;
    sb_q.push_back(e);
  endtask

  // Scoreboard monitor: every start pulse must match the oldest queued grant.
  always @(negedge clk) begin
    if (!reset && (bus.tx_start || bus.ack != '0)) begin
      check("ack_with_start", {31'd0, bus.tx_start}, 32'd1);
      if (sb_q.size() == 0) begin
        check("unexpected_grant", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("grant_id", 32'(bus.grant_id), 32'(e.id));
        check("tx_data", 32'(bus.tx_data), 32'(e.data));
        check("ack_onehot", 32'(bus.ack), 32'(4'b0001 << e.id));
      end
    end
  end

  task automatic wait_start();
    int n = 0;
    while (!bus.tx_start && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.tx_start) check("start_timeout", 32'd0, 32'd1);
  endtask

  // Transmitter model: busy rises after delay cycles, stays for len cycles.
  task automatic do_frame(input int delay, input int len);
    repeat (delay) @(negedge clk);
    bus.tx_busy = 1'b1;
    repeat (len) @(negedge clk);
    bus.tx_busy = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.req = '0;
    bus.tx_busy = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    bus.req     = '0;
    bus.data_in = '0;
    bus.tx_busy = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_tx_data", 32'(bus.tx_data), 32'd0);
    check("rst_tx_start", 32'(bus.tx_start), 32'd0);
    check("rst_ack", 32'(bus.ack), 32'd0);
    check("rst_grant_id", 32'(bus.grant_id), 32'd0);
    check("rst_active", 32'(bus.active), 32'd0);
    check("rst_timeout_err", 32'(bus.timeout_err), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single requester with exact one-cycle latency.
    bus.data_in = 32'h43A5_2110;
    bus.req     = 4'b0100;
    expect_grant(2, 8'hA5);
    @(negedge clk);
    check("t1_start_latency", 32'(bus.tx_start), 32'd1);
    bus.req = '0;
    repeat (2) @(negedge clk);
    bus.tx_busy = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("t1_active_busy", 32'(bus.active), 32'd1);
    end
    bus.tx_busy = 1'b0;
    @(negedge clk);
    check("t1_active_drop", 32'(bus.active), 32'd0);
    check("t1_tx_data_hold", 32'(bus.tx_data), 32'hA5);
    check("t1_grant_id_hold", 32'(bus.grant_id), 32'd2);

    // Round robin with all requesters asserted; each re-requests after its ack.
    do_reset();
    bus.data_in = 32'h4332_2110;
    expect_grant(0, 8'h10);
    expect_grant(1, 8'h21);
    expect_grant(2, 8'h32);
    expect_grant(3, 8'h43);
    expect_grant(0, 8'h10);
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_start();
      bus.req[bus.grant_id] = 1'b0;
      @(negedge clk);
      if (k < 4) bus.req = 4'b1111;
      do_frame(1, 4);
    end
    bus.req = '0;
    @(negedge clk);

    // Pointer wrap past 3 and skipping of idle requesters.
    bus.req = 4'b1000;
    expect_grant(3, 8'h43);
    wait_start();
    bus.req = '0;
    do_frame(1, 3);
    bus.req = 4'b0011;
    expect_grant(0, 8'h10);
    wait_start();
    bus.req = 4'b0010;
    expect_grant(1, 8'h21);
    do_frame(1, 3);
    wait_start();
    bus.req = '0;
    do_frame(1, 3);

    // Watchdog abort: error exactly TIMEOUT cycles after the start cycle.
    bus.req = 4'b0100;
    expect_grant(2, 8'h32);
    wait_start();
    bus.req = '0;
    for (int j = 1; j <= TIMEOUT; j++) begin
      @(negedge clk);
      if (j < TIMEOUT) check("t4_no_err_early", 32'(bus.timeout_err), 32'd0);
    end
    check("t4_timeout_err", 32'(bus.timeout_err), 32'd1);
    check("t4_idle_after_abort", 32'(bus.active), 32'd0);
    @(negedge clk);
    check("t4_err_one_cycle", 32'(bus.timeout_err), 32'd0);
    repeat (4) begin
      @(negedge clk);
      check("t4_no_second_ack", 32'(bus.ack), 32'd0);
    end

    // Busy sampled on the last possible edge counts as success.
    bus.req = 4'b1000;
    expect_grant(3, 8'h43);
    wait_start();
    bus.req = '0;
    repeat (TIMEOUT - 1) @(negedge clk);
    bus.tx_busy = 1'b1;
    @(negedge clk);
    check("t4b_no_err", 32'(bus.timeout_err), 32'd0);
    check("t4b_still_active", 32'(bus.active), 32'd1);
    repeat (3) @(negedge clk);
    bus.tx_busy = 1'b0;
    @(negedge clk);
    check("t4b_done", 32'(bus.active), 32'd0);

    // Transmitter busy across reset release blocks the grant.
    @(negedge clk);
    reset = 1'b1;
    bus.tx_busy = 1'b1;
    bus.req = 4'b0001;
    @(negedge clk);
    reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("t5_blocked", 32'(bus.tx_start), 32'd0);
    end
    bus.tx_busy = 1'b0;
    expect_grant(0, 8'h10);
    @(negedge clk);
    check("t5_start_after_busy", 32'(bus.tx_start), 32'd1);
    bus.req = '0;
    do_frame(1, 3);

    // Asynchronous reset in the middle of a frame (pointer is 1 beforehand).
    bus.req = 4'b0001;
    expect_grant(0, 8'h10);
    wait_start();
    bus.req = '0;
    @(negedge clk);
    bus.tx_busy = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_active", 32'(bus.active), 32'd0);
    check("t6_async_grant_id", 32'(bus.grant_id), 32'd0);
    check("t6_async_tx_data", 32'(bus.tx_data), 32'd0);
    check("t6_async_outputs", {28'd0, bus.tx_start, bus.timeout_err, 2'd0} | 32'(bus.ack), 32'd0);
    @(negedge clk);
    bus.tx_busy = 1'b0;
    reset = 1'b0;
    // A cleared pointer picks 0 before 3; a stale pointer of 1 would pick 3.
    bus.req = 4'b1001;
    expect_grant(0, 8'h10);
    wait_start();
    bus.req = '0;
    do_frame(1, 2);
    bus.req = 4'b1000;
    expect_grant(3, 8'h43);
    wait_start();
    check("t6_grant_id_3", 32'(bus.grant_id), 32'd3);
    bus.req = '0;
    do_frame(1, 2);

    repeat (2) @(negedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
